// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 2x2 max-pool sequencer.
package maxpool_pkg;

    // Sequencer state; one encoding shared by RTL and anything that peeks at it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Cycles spent in DRAIN: datapath latency of 2 plus one cycle of margin.
    localparam int DRAIN_CYCLES = 3;

    // Slot positions of the four pixels inside a pooling window.
    localparam int N_SLOTS = 4;
    localparam int TL      = 0;   // even row, even col
    localparam int TR      = 1;   // even row, odd col
    localparam int BL      = 2;   // odd row, even col
    localparam int BR      = 3;   // odd row, odd col

endpackage

// File: rtl/maxpool_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Holds the even-row pixel pairs until the matching odd row arrives.
module maxpool_line_buf #(
    parameter int DEPTH  = 112,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write the pair and capture the read word; the read holds until the next rd_en_i.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    // NOTE: the array has no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// 2x2 max-pool sequencer: turns a raster pixel stream into pooling windows.
// Optional build macro MAXPOOL_RELU_EN clamps negative pixels to 0 on accept.
module maxpool2x2_ctrl
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 224,
    parameter int IMG_HEIGHT = 224
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          valid_in,
    input  logic [DATA_WIDTH-1:0]                         data_in,
    output logic                                          ready_in,
    output logic                                          pool_valid,
    output logic [DATA_WIDTH-1:0]                         pool_in1,
    output logic [DATA_WIDTH-1:0]                         pool_in2,
    output logic [DATA_WIDTH-1:0]                         pool_in3,
    output logic [DATA_WIDTH-1:0]                         pool_in4,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT/4+1)-1:0]   win_cnt,
    output logic                                          busy,
    output logic                                          done
);

    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam int WIN_W     = $clog2(IMG_WIDTH*IMG_HEIGHT/4+1);
    localparam int BUF_DEPTH = IMG_WIDTH / 2;
    localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [1:0]       DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    state_e                  state_q;
    logic [1:0]              drain_q;
    logic                    ready_q, busy_q, done_q;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   win_q [N_SLOTS];
    logic                    pool_valid_q;

    logic                    accept, start_go, last_px, odd_row, odd_col;
    logic [DATA_WIDTH-1:0]   px;
    logic                    buf_we, buf_re;
    logic [BUF_AW-1:0]       buf_addr;
    logic [2*DATA_WIDTH-1:0] buf_rdata;

    // Accept qualification, pixel conditioning and next counter values.
    // NOTE: each output gets a default before any branch, so no latch is inferred.
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        px = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
        px = data_in;
`endif
        accept    = valid_in & ready_q;
        start_go  = (state_q == IDLE) & start;
        odd_row   = row_q[0];
        odd_col   = col_q[0];
        last_px   = accept & (row_q == ROW_LAST) & (col_q == COL_LAST);
        buf_we    = accept & ~odd_row & odd_col;
        buf_re    = accept & odd_row & ~odd_col;
        buf_addr  = BUF_AW'(col_q >> 1);
        col_d     = col_q;
        row_d     = row_q;
        win_cnt_d = win_cnt_q;
        if (start_go) begin
            col_d     = '0;
            row_d     = '0;
            win_cnt_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (odd_row & odd_col) begin
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end
    end

    // Position counters and window count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Hold register and window assembly; pool_valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            win_q        <= '{default: '0};
            pool_valid_q <= 1'b0;
        end else begin
            pool_valid_q <= 1'b0;
            if (accept) begin
                if (!odd_col) begin
                    hold_q <= px;
                end else if (odd_row) begin
                    win_q[TL]    <= buf_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                    win_q[TR]    <= buf_rdata[DATA_WIDTH-1:0];
                    win_q[BL]    <= hold_q;
                    win_q[BR]    <= px;
                    pool_valid_q <= 1'b1;
                end
            end
        end
    end

    // Sequencer FSM with registered ready/busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            drain_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_px) begin
                        state_q <= DRAIN;
                        ready_q <= 1'b0;
                        drain_q <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    maxpool_line_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2*DATA_WIDTH),
        .ADDR_W(BUF_AW)
    ) u_line_buf (
        .clk      (clk),
        .wr_en_i  (buf_we),
        .wr_addr_i(buf_addr),
        .wr_data_i({hold_q, px}),
        .rd_en_i  (buf_re),
        .rd_addr_i(buf_addr),
        .rd_data_o(buf_rdata)
    );

    assign ready_in   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pool_valid = pool_valid_q;
    assign win_cnt    = win_cnt_q;
    assign pool_in1   = win_q[TL];
    assign pool_in2   = win_q[TR];
    assign pool_in3   = win_q[BL];
    assign pool_in4   = win_q[BR];

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Directed bench for maxpool2x2_ctrl: a 4x4 instance and a 2x2 instance.
module tb_maxpool2x2_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    // 4x4 instance
    logic        start, valid_in;
    logic [31:0] data_in;
    logic        ready_in, pool_valid, busy, done;
    logic [31:0] pool_in1, pool_in2, pool_in3, pool_in4;
    logic [2:0]  win_cnt;

    // 2x2 instance
    logic        start2, valid2;
    logic [31:0] data2;
    logic        ready2, pv2, busy2, done2;
    logic [31:0] p2_1, p2_2, p2_3, p2_4;
    logic [0:0]  wc2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  pix [16];
    logic [127:0] wins [$];
    int           pv_run_err = 0;
    logic         pv_prev    = 1'b0;

    // Expected windows for the 0..15 raster stream.
    logic [127:0] exp_seq [4] = '{
        {32'd0,  32'd1,  32'd4,  32'd5},
        {32'd2,  32'd3,  32'd6,  32'd7},
        {32'd8,  32'd9,  32'd12, 32'd13},
        {32'd10, 32'd11, 32'd14, 32'd15}
    };

    always #5 clk = ~clk;

    maxpool2x2_ctrl #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .pool_valid(pool_valid),
        .pool_in1(pool_in1), .pool_in2(pool_in2), .pool_in3(pool_in3), .pool_in4(pool_in4),
        .win_cnt(win_cnt), .busy(busy), .done(done)
    );

    maxpool2x2_ctrl #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .valid_in(valid2), .data_in(data2),
        .ready_in(ready2), .pool_valid(pv2),
        .pool_in1(p2_1), .pool_in2(p2_2), .pool_in3(p2_3), .pool_in4(p2_4),
        .win_cnt(wc2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window collector for the 4x4 instance; also flags back-to-back pool_valid.
    always @(negedge clk) begin
        if (pool_valid) wins.push_back({pool_in1, pool_in2, pool_in3, pool_in4});
        if (pool_valid && pv_prev) pv_run_err++;
        pv_prev = pool_valid;
    end

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 32'(i);
    endtask

    task automatic start_map(input string tag);
        wins.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ready"}, ready_in, 1'b1);
    endtask

    // Drive n pixels from pix[]; optional idle cycle before each; start pulsed at pixel start_at.
    task automatic feed(input int n, input bit gaps, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                valid_in = 1'b0;
                @(negedge clk);
            end
            valid_in = 1'b1;
            data_in  = pix[i];
            start    = (i == start_at);
            @(negedge clk);
            start    = 1'b0;
        end
        valid_in = 1'b0;
    endtask

    // Called on the negedge after the last accept: latency, drain and done pulse.
    task automatic finish_map(input string tag);
        int d_seen = -1;
        int d_cnt  = 0;
        check({tag, "_pv_lat"}, pool_valid, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (done) begin
                d_cnt++;
                if (d_seen < 0) d_seen = k;
            end
            @(negedge clk);
        end
        check({tag, "_done_lat"}, d_seen, 3);
        check({tag, "_done_w"}, d_cnt, 1);
        check({tag, "_idle"}, {ready_in, busy}, 2'b00);
        check({tag, "_wcnt"}, win_cnt, 3'd4);
        check({tag, "_nwin"}, wins.size(), 4);
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_win%0d", tag, i), (i < wins.size()) ? wins[i] : '1, exp_seq[i]);
        check({tag, "_pv_width"}, pv_run_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v2 [4];
        logic [127:0] exp_neg;
        int d_seen;

        reset = 1'b1;
        start = 1'b0; valid_in = 1'b0; data_in = '0;
        start2 = 1'b0; valid2 = 1'b0; data2 = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ctl", {ready_in, busy, done, pool_valid, win_cnt}, '0);
        check("rst_pool", {pool_in1, pool_in2, pool_in3, pool_in4}, '0);
        check("rst_ctl2", {ready2, busy2, done2, pv2, wc2}, '0);
        reset = 1'b0;
        @(negedge clk);

        // 4x4 ramp, no gaps
        load_ramp();
        start_map("nogap");
        check("nogap_busy", busy, 1'b1);
        feed(16, 1'b0, -1);
        finish_map("nogap");
        check_seq("nogap");

        // 4x4 ramp, valid_in every other cycle
        start_map("gap");
        feed(16, 1'b1, -1);
        finish_map("gap");
        check_seq("gap");

        // Negative first window
        pix[0] = 32'hFFFF_FFFB;  // -5
        pix[1] = 32'hFFFF_FFFD;  // -3
        pix[4] = 32'hFFFF_FFF8;  // -8
        pix[5] = 32'hFFFF_FFFF;  // -1
`ifdef MAXPOOL_RELU_EN
        exp_neg = '0;
`else
        exp_neg = {32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
`endif
        start_map("neg");
        feed(16, 1'b0, -1);
        finish_map("neg");
        check("neg_win0", (wins.size() > 0) ? wins[0] : '1, exp_neg);
        check("neg_win1", (wins.size() > 1) ? wins[1] : '1, exp_seq[1]);
        load_ramp();

        // start pulsed during RUN is ignored
        start_map("restart");
        feed(16, 1'b0, 6);
        finish_map("restart");
        check_seq("restart");

        // Asynchronous reset mid-map, then a fresh map
        start_map("abort");
        feed(9, 1'b0, -1);
        check("abort_wcnt_mid", win_cnt, 3'd2);
        #2 reset = 1'b1;
        #1;
        check("abort_rst_ctl", {ready_in, busy, done, pool_valid, win_cnt}, '0);
        check("abort_rst_pool", {pool_in1, pool_in2, pool_in3, pool_in4}, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_map("fresh");
        feed(16, 1'b0, -1);
        finish_map("fresh");
        check_seq("fresh");

        // 2x2 single window
        v2 = '{32'd7, 32'd3, 32'd9, 32'd1};
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sq_ready", ready2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            valid2 = 1'b1;
            data2  = v2[i];
            if (i == 3) check("sq_pv_pre", pv2, 1'b0);
            @(negedge clk);
        end
        valid2 = 1'b0;
        check("sq_pv", pv2, 1'b1);
        check("sq_win", {p2_1, p2_2, p2_3, p2_4}, {32'd7, 32'd3, 32'd9, 32'd1});
        check("sq_wcnt", wc2, 1'b1);
        d_seen = -1;
        for (int k = 0; k < 6; k++) begin
            if (done2 && d_seen < 0) d_seen = k;
            @(negedge clk);
        end
        check("sq_done_lat", d_seen, 3);
        check("sq_idle", {ready2, busy2, done2}, 3'b000);
        check("sq_hold", {p2_1, p2_2, p2_3, p2_4}, {32'd7, 32'd3, 32'd9, 32'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
